miim_master: RTL and testbench

MIIM (MDIO/MDC) management master that reads and writes PHY registers with IEEE 802.3 clause-22 frames. It replaces the tied-off `phyN_mdc` / floating `phyN_mio` in the GigE tap top level: one instance per PHY, running on `clk_50`, and enabled once the PHY power/strap sequencer reaches READY. The block accepts one command at a time over a valid/ready handshake and returns read data, or a no-PHY error, through a one-cycle response strobe. The pad tristate stays in the top level: `phyN_mio = mdio_oe ? mdio_o : 1'bz`.

---
 rtl/miim_pkg.sv | 27 ++
 rtl/miim_clk_gen.sv | 41 ++++
 rtl/miim_master.sv | 147 ++++++++++++++
 tb/tb_miim_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miim_pkg.sv
// Shared constants, state encoding and frame builder for the clause-22 MIIM master.
package miim_pkg;

  localparam logic [1:0] MIIM_ST       = 2'b01;
  localparam logic [1:0] MIIM_OP_WRITE = 2'b01;
  localparam logic [1:0] MIIM_OP_READ  = 2'b10;
  localparam logic [1:0] MIIM_TA_WRITE = 2'b10;
  localparam int         MIIM_PRE_BITS   = 32;
  localparam int         MIIM_FRAME_BITS = 64;

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL, DONE} miim_state_t;

  // Frame bit 0 lands in the MSB; read TA/data positions are never driven.
  function automatic logic [MIIM_FRAME_BITS-1:0] miim_frame(
    input logic        write,
    input logic [4:0]  phyad,
    input logic [4:0]  regad,
    input logic [15:0] wdata
  );
    return {{MIIM_PRE_BITS{1'b1}}, MIIM_ST,
            write ? MIIM_OP_WRITE : MIIM_OP_READ,
            phyad, regad,
            write ? MIIM_TA_WRITE : 2'b11,
            write ? wdata : 16'hFFFF};
  endfunction

endpackage

// File: rtl/miim_clk_gen.sv
// MDC divider: low phase first, CLK_DIV clocks per half period, held low while not running.
module miim_clk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic run_i,
  output logic mdc_o,
  output logic fall_stb_o,
  output logic rise_stb_o
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             mdc_q;
  logic             phase_end_s;

  // Strobes flag the last clock of a phase, so registered users switch with mdc.
  assign phase_end_s = run_i & (div_q == DIV_LAST);
  assign fall_stb_o  = phase_end_s & mdc_q;
  assign rise_stb_o  = phase_end_s & ~mdc_q;
  assign mdc_o       = mdc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else if (!run_i) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else if (phase_end_s) begin
      div_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/miim_master.sv
// Clause-22 MDIO/MDC management master, one command at a time.
// Optional MIIM_PREAMBLE_SUPPRESS_EN adds cmd_no_pre to skip the 32-bit preamble.
module miim_master
  import miim_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
`ifdef MIIM_PREAMBLE_SUPPRESS_EN
  input  logic        cmd_no_pre,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [6:0] LAST_BIT = 7'(MIIM_FRAME_BITS - 1);

  miim_state_t                state_q;
  logic [MIIM_FRAME_BITS-1:0] sr_q, frame_d;
  logic [6:0]                 bit_q, start_d, next_bit_s;
  logic                       write_q, err_q, ready_q;
  logic                       mdio_o_q, mdio_oe_q;
  logic                       rsp_valid_q, rsp_error_q;
  logic [15:0]                rx_q, rsp_rdata_q;
  logic                       run_s, fall_stb_s, rise_stb_s;

  assign run_s      = (state_q == SHIFT) | (state_q == TAIL);
  assign next_bit_s = bit_q + 7'd1;

  miim_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clock      (clock),
    .reset      (reset),
    .run_i      (run_s),
    .mdc_o      (mdc),
    .fall_stb_o (fall_stb_s),
    .rise_stb_o (rise_stb_s)
  );

  // Short frames are pre-shifted so ST is the first bit out; bit_q keeps full-frame numbering.
  always_comb begin
    frame_d = miim_frame(cmd_write, cmd_phyad, cmd_regad, cmd_wdata);
    start_d = 7'd0;
`ifdef MIIM_PREAMBLE_SUPPRESS_EN
    if (cmd_no_pre) begin
      frame_d = frame_d << MIIM_PRE_BITS;
      start_d = 7'(MIIM_PRE_BITS);
    end else begin
      start_d = 7'd0;
    end
`endif
  end

  // Transaction FSM with frame shifter, MDIO sampler and registered response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_q       <= 7'd0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      rx_q        <= 16'h0000;
      ready_q     <= 1'b1;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          if (cmd_valid) begin
            state_q   <= SHIFT;
            ready_q   <= 1'b0;
            sr_q      <= frame_d << 1;
            mdio_o_q  <= frame_d[MIIM_FRAME_BITS-1];
            mdio_oe_q <= 1'b1;
            bit_q     <= start_d;
            write_q   <= cmd_write;
            err_q     <= 1'b0;
          end
        end
        SHIFT: begin
          if (rise_stb_s && !write_q) begin
            if (bit_q == 7'd47) begin
              err_q <= mdio_i;
            end else if (bit_q >= 7'd48) begin
              rx_q <= {rx_q[14:0], mdio_i};
            end
          end
          if (fall_stb_s) begin
            if (bit_q == LAST_BIT) begin
              state_q   <= TAIL;
              mdio_o_q  <= 1'b1;
              mdio_oe_q <= 1'b0;
            end else begin
              bit_q     <= next_bit_s;
              mdio_o_q  <= sr_q[MIIM_FRAME_BITS-1];
              sr_q      <= sr_q << 1;
              // Reads release the line from TA onward.
              mdio_oe_q <= write_q | (next_bit_s < 7'd46);
            end
          end
        end
        TAIL: begin
          if (fall_stb_s) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= write_q ? 16'h0000 : rx_q;
            rsp_error_q <= ~write_q & err_q;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = ~ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_miim_master.sv
// Scoreboard bench for miim_master: random clause-22 commands, PHY model and frame/response checks.
module tb_miim_master;

  localparam int DIV = 10;

  typedef struct {
    logic        write;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic        no_pre;
    logic        phy_present;
    logic [15:0] phy_data;
    logic        b2b;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phyad = 5'd0;
  logic [4:0]  cmd_regad = 5'd0;
  logic [15:0] cmd_wdata = 16'h0000;
  logic        cmd_no_pre = 1'b0;
  logic        mdio_i = 1'b1;
  logic        cmd_ready, rsp_valid, rsp_error, busy, mdc, mdio_o, mdio_oe;
  logic [15:0] rsp_rdata;

  int   checks = 0;
  int   failures = 0;
  txn_t exp_q[$];

  miim_master #(.CLK_DIV(DIV)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_phyad (cmd_phyad),
    .cmd_regad (cmd_regad),
    .cmd_wdata (cmd_wdata),
`ifdef MIIM_PREAMBLE_SUPPRESS_EN
    .cmd_no_pre(cmd_no_pre),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .busy      (busy),
    .mdc       (mdc),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .mdio_i    (mdio_i)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected {oe, o} seen at the MDC rising edge of full-frame bit b (64 = idle bit).
  function automatic logic [1:0] exp_line(input txn_t t, input int b);
    if (b >= 64) return 2'b00;
    if (!t.write && b >= 46) return 2'b00;
    if (b < 32) return 2'b11;
    if (b == 32) return 2'b10;
    if (b == 33) return 2'b11;
    if (b == 34) return {1'b1, ~t.write};
    if (b == 35) return {1'b1, t.write};
    if (b <= 40) return {1'b1, t.phyad[40-b]};
    if (b <= 45) return {1'b1, t.regad[45-b]};
    if (b == 46) return 2'b11;
    if (b == 47) return 2'b10;
    return {1'b1, t.wdata[63-b]};
  endfunction

  // What the PHY (or the pull-up) puts on MDIO during full-frame bit b.
  function automatic logic phy_bit(input txn_t t, input int b);
    if (t.write || !t.phy_present) return 1'b1;
    if (b == 47) return 1'b0;
    if (b >= 48 && b <= 63) return t.phy_data[63-b];
    return 1'b1;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.write       = 1'($urandom_range(0, 1));
    t.phyad       = 5'($urandom);
    t.regad       = 5'($urandom);
    t.wdata       = 16'($urandom);
    t.phy_present = ($urandom_range(0, 3) != 0);
    t.phy_data    = 16'($urandom);
`ifdef MIIM_PREAMBLE_SUPPRESS_EN
    t.no_pre      = 1'($urandom_range(0, 1));
`else
    t.no_pre      = 1'b0;
`endif
    t.b2b         = 1'b0;
    return t;
  endfunction

  // Monitor / PHY model: observes #1 after every rising clock edge.
  txn_t cur;
  bit   mon_active = 1'b0;
  int   rise_cnt = 0, start_bit = 0, cyc = 0, acc_cyc = 0, last_rsp_cyc = -100;
  logic mdc_prev = 1'b0, rsp_prev = 1'b0, ready_prev = 1'b1;

  always begin
    @(posedge clock);
    #1;
    cyc++;
    if (reset) begin
      mon_active = 1'b0;
      rise_cnt   = 0;
      mdio_i     = 1'b1;
      mdc_prev   = mdc;
      rsp_prev   = rsp_valid;
      ready_prev = cmd_ready;
    end else begin
      if (cmd_valid && ready_prev) begin
        if (exp_q.size() == 0) begin
          check("accept_unexpected", 32'd1, 32'd0);
        end else begin
          cur        = exp_q[0];
          mon_active = 1'b1;
          rise_cnt   = 0;
          acc_cyc    = cyc;
          start_bit  = cur.no_pre ? 32 : 0;
          if (cur.b2b) check("b2b_accept_cycle", 32'(cyc - last_rsp_cyc), 32'd2);
        end
      end
      if (mdc && !mdc_prev && mon_active) begin
        int b;
        logic [1:0] e;
        b = start_bit + rise_cnt;
        e = exp_line(cur, b);
        if (e[1]) check($sformatf("frame_bit%0d", b), {30'd0, mdio_oe, mdio_o}, {30'd0, e});
        else      check($sformatf("frame_oe%0d", b), {31'd0, mdio_oe}, 32'd0);
        rise_cnt++;
      end
      mdio_i = mon_active ? phy_bit(cur, start_bit + rise_cnt) : 1'b1;
      if (rsp_valid) begin
        if (rsp_prev) begin
          check("rsp_pulse_width", 32'd2, 32'd1);
        end else if (!mon_active || exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          check("rsp_latency", 32'(cyc - acc_cyc + 1), 32'((65 - start_bit) * 2 * DIV + 1));
          check("rsp_rdata", {16'd0, rsp_rdata},
                {16'd0, t.write ? 16'h0000 : (t.phy_present ? t.phy_data : 16'hFFFF)});
          check("rsp_error", {31'd0, rsp_error}, {31'd0, ~t.write & ~t.phy_present});
          check("rsp_ready_busy", {30'd0, cmd_ready, busy}, 32'd1);
          check("mdc_rise_count", 32'(rise_cnt), 32'(65 - start_bit));
          mon_active   = 1'b0;
          last_rsp_cyc = cyc;
        end
      end
      mdc_prev   = mdc;
      rsp_prev   = rsp_valid;
      ready_prev = cmd_ready;
    end
  end

  task automatic issue(input txn_t t, input bit hold);
    int n;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_write = t.write;
    cmd_phyad = t.phyad;
    cmd_regad = t.regad;
    cmd_wdata = t.wdata;
    cmd_no_pre = t.no_pre;
    exp_q.push_back(t);
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      exp_q.delete();
    end else begin
      @(posedge clock);
      if (!hold) begin
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_write = ~cmd_write;
        cmd_phyad = 5'($urandom);
        cmd_regad = 5'($urandom);
        cmd_wdata = 16'($urandom);
        cmd_no_pre = ~cmd_no_pre;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    txn_t t, t2;
    repeat (3) @(negedge clock);
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_busy",      {31'd0, busy},      32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
    check("reset_mdc",       {31'd0, mdc},       32'd0);
    check("reset_mdio_o",    {31'd0, mdio_o},    32'd1);
    check("reset_mdio_oe",   {31'd0, mdio_oe},   32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Directed write, PHY read, no-PHY read.
    t = rand_txn();
    t.write = 1'b1; t.phyad = 5'd0; t.regad = 5'd0; t.wdata = 16'h1140; t.no_pre = 1'b0;
    issue(t, 1'b0);
    wait_idle();
    t = rand_txn();
    t.write = 1'b0; t.phyad = 5'd0; t.regad = 5'd2; t.phy_present = 1'b1; t.phy_data = 16'h0141; t.no_pre = 1'b0;
    issue(t, 1'b0);
    wait_idle();
    t.phy_present = 1'b0; t.regad = 5'd3;
    issue(t, 1'b0);
    wait_idle();

    // Back-to-back with cmd_valid held; second command's fields sit on the bus during the first frame.
    t = rand_txn();
    t2 = rand_txn();
    t2.b2b = 1'b1;
    issue(t, 1'b1);
    issue(t2, 1'b0);
    wait_idle();

    // Reset during the high phase of bit 40.
    t = rand_txn();
    t.no_pre = 1'b0;
    issue(t, 1'b0);
    repeat (80 * DIV + DIV + 2) @(negedge clock);
    check("mdc_before_reset", {31'd0, mdc}, 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_mdc",       {31'd0, mdc},       32'd0);
    check("midreset_mdio_oe",   {31'd0, mdio_oe},   32'd0);
    check("midreset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (600) @(negedge clock);
    t = rand_txn();
    t.no_pre = 1'b0;
    issue(t, 1'b0);
    wait_idle();

`ifdef MIIM_PREAMBLE_SUPPRESS_EN
    t = rand_txn();
    t.no_pre = 1'b1;
    issue(t, 1'b0);
    wait_idle();
`endif

    // Randomized traffic.
    for (int i = 0; i < 8; i++) begin
      t = rand_txn();
      issue(t, 1'b0);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (20) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
